// File: rtl/match_logger.sv
// match_logger: buffers match events and logs them as two-word records to capture memory.
// Define LOGGER_WRAP_EN to let the address wrap and overwrite old records instead of stopping at full.
module match_logger #(
  parameter int ADDR_W = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              match,
  input  logic [31:0]       match_data,
  input  logic [7:0]        match_tag,
  input  logic              mem_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W-1:0] rec_count,
  output logic [15:0]       drop_count,
  output logic              busy,
  output logic              log_full
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, WR_HDR = 2'd1, WR_DATA = 2'd2;
  localparam logic [ADDR_W-1:0] CAP = {1'b1, {(ADDR_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0] LAST = CAP - 1'b1;
  logic [39:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [PW:0] count;
  logic [1:0] state;
  logic [15:0] seq;
  logic [39:0] head;
  logic [7:0] nxt_tag;
  logic empty, full, hdr_ok, done, push, full_hit;
  logic [ADDR_W-1:0] rec_next;
  assign rd_nxt = rd_ptr + 1'b1;
  assign head = fifo[rd_ptr];
  assign nxt_tag = fifo[rd_nxt][39:32];
  assign empty = count == '0;
  assign full = count == (PW+1)'(FIFO_DEPTH);
  assign hdr_ok = state == WR_HDR && mem_ready;
  assign done = state == WR_DATA && mem_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push = match && !log_full && (!full || done);
  assign rec_next = rec_count == CAP ? rec_count : rec_count + 1'b1;
  assign busy = state != IDLE || !empty;
`ifdef LOGGER_WRAP_EN
  assign full_hit = 1'b0;
  assign log_full = 1'b0;
`else
  assign full_hit = done && rec_count == LAST;
  always_ff @(posedge clk)
    log_full <= rst ? 1'b0 : log_full | full_hit;
`endif
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= {match_tag, match_data};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rec_count <= '0;
      drop_count <= '0;
      seq <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (done) rd_ptr <= rd_nxt;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, done};
      if (match && !push && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (state == IDLE && !empty && !log_full) begin
        state <= WR_HDR;
        mem_wr <= 1'b1;
        mem_wdata <= {seq, head[39:32], 8'hA5};
      end else if (hdr_ok) begin
        state <= WR_DATA;
        mem_addr <= mem_addr + 1'b1;
        mem_wdata <= head[31:0];
      end else if (done) begin
        mem_addr <= mem_addr + 1'b1;
        seq <= seq + 16'd1;
        rec_count <= rec_next;
        state <= count > (PW+1)'(1) && !full_hit ? WR_HDR : IDLE;
        mem_wr <= count > (PW+1)'(1) && !full_hit;
        if (count > (PW+1)'(1)) mem_wdata <= {seq + 16'd1, nxt_tag, 8'hA5};
      end
    end
  end
endmodule

// File: tb/tb_match_logger.sv
// tb_match_logger: scoreboard bench for match_logger (ADDR_W=4, FIFO_DEPTH=4).
module tb_match_logger;
  localparam int AW = 4;
  logic clk = 0, rst = 1, match = 0, mem_ready = 0;
  logic [31:0] match_data = 0;
  logic [7:0] match_tag = 0;
  logic mem_wr, busy, log_full;
  logic [AW-1:0] mem_addr, rec_count;
  logic [31:0] mem_wdata;
  logic [15:0] drop_count;
  int n_cmp = 0, n_err = 0;
  logic [AW+31:0] exp_q[$], obs_q[$];
  logic [AW+31:0] e, o;
  logic [AW-1:0] m_addr;
  logic [15:0] m_seq;

  match_logger #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .match(match), .match_data(match_data), .match_tag(match_tag),
    .mem_ready(mem_ready), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rec_count(rec_count), .drop_count(drop_count), .busy(busy), .log_full(log_full)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && mem_wr && mem_ready) obs_q.push_back({mem_addr, mem_wdata});

  task tick();
    @(posedge clk);
    #1;
  endtask

  task do_reset();
    rst = 1;
    match = 0;
    tick();
    tick();
    rst = 0;
    m_addr = 0;
    m_seq = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task send(input logic [31:0] d, input logic [7:0] t, input bit acc);
    match = 1;
    match_data = d;
    match_tag = t;
    if (acc) begin
      exp_q.push_back({m_addr, m_seq, t, 8'hA5});
      exp_q.push_back({m_addr + 4'd1, d});
      m_addr = m_addr + 4'd2;
      m_seq = m_seq + 16'd1;
    end
    tick();
    match = 0;
  endtask

  task test_reset();
    do_reset();
    n_cmp++;
    if ({mem_wr, busy, log_full} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got wr/busy/full=%b, want 000", {mem_wr, busy, log_full});
    end
    n_cmp++;
    if (mem_addr !== 0 || mem_wdata !== 0) begin
      n_err++;
      $display("FAIL reset_mem: got addr=%h data=%h, want 0/0", mem_addr, mem_wdata);
    end
    n_cmp++;
    if (rec_count !== 0 || drop_count !== 0) begin
      n_err++;
      $display("FAIL reset_counts: got rec=%0d drop=%0d, want 0/0", rec_count, drop_count);
    end
  endtask

  task test_single();
    mem_ready = 1;
    send(32'hDEADBEEF, 8'h03, 1);
    n_cmp++;
    if (mem_wr !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_latency: got wr=%b busy=%b, want 0/1", mem_wr, busy);
    end
    tick();
    n_cmp++;
    if (mem_wr !== 1'b1 || mem_addr !== 4'd0 || mem_wdata !== 32'h000003A5) begin
      n_err++;
      $display("FAIL single_hdr: got wr=%b addr=%h data=%h, want 1/0/000003a5", mem_wr, mem_addr, mem_wdata);
    end
    tick();
    n_cmp++;
    if (mem_wr !== 1'b1 || mem_addr !== 4'd1 || mem_wdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL single_data: got wr=%b addr=%h data=%h, want 1/1/deadbeef", mem_wr, mem_addr, mem_wdata);
    end
    tick();
    n_cmp++;
    if (mem_wr !== 1'b0 || rec_count !== 4'd1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_done: got wr=%b rec=%0d busy=%b, want 0/1/0", mem_wr, rec_count, busy);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL single_write: got addr=%h data=%h, want addr=%h data=%h", o[AW+31:32], o[31:0], e[AW+31:32], e[31:0]);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_err++;
      $display("FAIL single_leftover: got %0d unexpected writes, want %0d missing=0", obs_q.size(), exp_q.size());
    end
  endtask

  task test_backpressure();
    mem_ready = 0;
    send(32'hCAFEF00D, 8'h5A, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (mem_wr !== 1'b1 || mem_addr !== 4'd2 || mem_wdata !== 32'h00015AA5) begin
        n_err++;
        $display("FAIL bp_hold%0d: got wr=%b addr=%h data=%h, want 1/2/00015aa5", i, mem_wr, mem_addr, mem_wdata);
      end
      tick();
    end
    mem_ready = 1;
    tick();
    tick();
    n_cmp++;
    if (mem_wr !== 1'b0 || rec_count !== 4'd2) begin
      n_err++;
      $display("FAIL bp_done: got wr=%b rec=%0d, want 0/2", mem_wr, rec_count);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL bp_write: got addr=%h data=%h, want addr=%h data=%h", o[AW+31:32], o[31:0], e[AW+31:32], e[31:0]);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_leftover: got %0d unexpected writes, want %0d missing=0", obs_q.size(), exp_q.size());
    end
  endtask

  task test_back_to_back();
    int gaps;
    gaps = 0;
    mem_ready = 0;
    for (int i = 0; i < 6; i++) send(32'h1000 + 32'(i), 8'(i), i < 4);
    n_cmp++;
    if (drop_count !== 16'd2 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_drop: got drop=%0d busy=%b, want 2/1", drop_count, busy);
    end
    mem_ready = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 7 && mem_wr !== 1'b1) gaps++;
    end
    n_cmp++;
    if (gaps != 0 || mem_wr !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gaps: got gaps=%0d final_wr=%b, want 0/0", gaps, mem_wr);
    end
    n_cmp++;
    if (rec_count !== 4'd6 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done: got rec=%0d busy=%b, want 6/0", rec_count, busy);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL b2b_write: got addr=%h data=%h, want addr=%h data=%h", o[AW+31:32], o[31:0], e[AW+31:32], e[31:0]);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_leftover: got %0d unexpected writes, want %0d missing=0", obs_q.size(), exp_q.size());
    end
  endtask

  task test_full();
    do_reset();
    mem_ready = 1;
    for (int i = 0; i < 8; i++) begin
      send(32'hA000 + 32'(i), 8'h10 + 8'(i), 1);
      tick();
      tick();
    end
    repeat (3) tick();
`ifdef LOGGER_WRAP_EN
    send(32'hA008, 8'h18, 1);
    repeat (6) tick();
    n_cmp++;
    if (log_full !== 1'b0 || rec_count !== 4'd8 || drop_count !== 16'd0) begin
      n_err++;
      $display("FAIL wrap_state: got full=%b rec=%0d drop=%0d, want 0/8/0", log_full, rec_count, drop_count);
    end
`else
    n_cmp++;
    if (log_full !== 1'b1 || rec_count !== 4'd8 || mem_addr !== 4'd0) begin
      n_err++;
      $display("FAIL full_set: got full=%b rec=%0d addr=%h, want 1/8/0", log_full, rec_count, mem_addr);
    end
    send(32'hA008, 8'h18, 0);
    repeat (6) tick();
    n_cmp++;
    if (drop_count !== 16'd1 || mem_wr !== 1'b0 || busy !== 1'b0 || log_full !== 1'b1) begin
      n_err++;
      $display("FAIL full_drop: got drop=%0d wr=%b busy=%b full=%b, want 1/0/0/1", drop_count, mem_wr, busy, log_full);
    end
`endif
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL full_write: got addr=%h data=%h, want addr=%h data=%h", o[AW+31:32], o[31:0], e[AW+31:32], e[31:0]);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_err++;
      $display("FAIL full_leftover: got %0d unexpected writes, want %0d missing=0", obs_q.size(), exp_q.size());
    end
  endtask

  task test_reset_mid();
    do_reset();
    mem_ready = 1;
    send(32'h12345678, 8'h77, 1);
    tick();
    tick();
    n_cmp++;
    if (mem_wr !== 1'b1 || mem_wdata !== 32'h12345678) begin
      n_err++;
      $display("FAIL mid_in_data: got wr=%b data=%h, want 1/12345678", mem_wr, mem_wdata);
    end
    mem_ready = 0;
    rst = 1;
    tick();
    n_cmp++;
    if (mem_wr !== 1'b0 || mem_addr !== 0 || mem_wdata !== 0 || rec_count !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got wr=%b addr=%h data=%h rec=%0d busy=%b, want all 0", mem_wr, mem_addr, mem_wdata, rec_count, busy);
    end
    rst = 0;
    void'(exp_q.pop_back());
    m_addr = 0;
    m_seq = 0;
    mem_ready = 1;
    send(32'h0BADF00D, 8'h21, 1);
    repeat (4) tick();
    n_cmp++;
    if (rec_count !== 4'd1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_relog: got rec=%0d busy=%b, want 1/0", rec_count, busy);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL mid_write: got addr=%h data=%h, want addr=%h data=%h", o[AW+31:32], o[31:0], e[AW+31:32], e[31:0]);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_err++;
      $display("FAIL mid_leftover: got %0d unexpected writes, want %0d missing=0", obs_q.size(), exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/match_logger.md
# match_logger

Downstream stage of the sniffer controller: accepts one-cycle match events, each carrying the matched 32-bit data word and an 8-bit rule tag. It buffers them in a small FIFO and writes each as a two-word record into the capture memory, using an auto-incrementing address. It counts stored and dropped records and flags when the log is full.

## Interface
Parameters:
- ADDR_W, 10, capture-memory word-address width; capacity = 2^(ADDR_W-1) records
- FIFO_DEPTH, 4, pending-match buffer entries (power of two, ≥2)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- match  in  1  one-cycle pulse: contents compared equal
- match_data  in  32  data word that matched, valid with match
- match_tag  in  8  rule/comparator index, valid with match
- mem_ready  in  1  memory accepts the write presented this cycle
- mem_wr  out  1  write request
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  write data
- rec_count  out  ADDR_W  records fully written
- drop_count  out  16  matches discarded, saturating at 0xFFFF
- busy  out  1  FIFO non-empty or FSM not IDLE
- log_full  out  1  capacity reached (non-wrap build only)

## Operation
- Reset values: mem_wr=0, mem_addr=0, mem_wdata=0, rec_count=0, drop_count=0, busy=0, log_full=0. FIFO is emptied, seq=0, and the FSM enters IDLE.
- Push: a match sampled at an edge pushes {match_tag, match_data} unless the FIFO is full or log_full=1. In either of those cases the match is dropped and drop_count increments (saturating).
- Simultaneous push and pop on a full FIFO: the push is accepted.
- Record format, in word order:
  - header = {seq[15:0], tag[7:0], 8'hA5} at an even address
  - then match_data at the following odd address
- seq is a 16-bit sequence counter, incremented per completed record, wrapping 0xFFFF→0x0000. It continues counting across address wrap.
- FSM states:
  - IDLE: if the FIFO is non-empty and log_full=0, go to WR_HDR.
  - WR_HDR: mem_wr=1, mem_wdata=header. On mem_ready, mem_addr+1 and go to WR_DATA.
  - WR_DATA: mem_wr=1, mem_wdata=data. On mem_ready, mem_addr+1, pop FIFO, seq+1, rec_count update. Then go to WR_HDR if the FIFO still holds an entry (after the pop) and not full-stopped; otherwise go to IDLE.
- mem_wr, mem_addr and mem_wdata are registered. They hold stable while mem_wr=1 and mem_ready=0 (no timeout).
- Address arithmetic is modulo 2^ADDR_W.
- Reset mid-record: the partial record is abandoned with no header-only completion. mem_wr is 0 after the reset edge.

## Timing
- Match sampled at edge k with the FSM idle and the FIFO empty:
  - entry visible at edge k
  - FSM enters WR_HDR at edge k+1, so mem_wr is high during cycle k+1→k+2
- With mem_ready held high, a record takes exactly 2 cycles. Back-to-back records have no idle cycle between them.
- Throughput is limited to one record per 2 cycles. Sustained matches on every cycle overflow the FIFO and are dropped.
- rec_count, seq and the pop all update at the same edge that accepts the data word.
- busy is combinational from the registered state: (state≠IDLE) | fifo_nonempty.

## Configuration
- LOGGER_WRAP_EN defined:
  - mem_addr wraps from 2^ADDR_W−1 to 0 and overwrites the oldest records.
  - log_full is tied to 0.
  - rec_count saturates at 2^(ADDR_W-1).
- LOGGER_WRAP_EN undefined:
  - log_full sets at the edge completing record number 2^(ADDR_W-1), with mem_addr back at 0.
  - Afterwards the FSM stays in IDLE and further matches are dropped and counted.
  - FIFO contents are retained but not written.
  - Only rst clears log_full.

## Test plan
- Single event: rst, then match with data=0xDEADBEEF, tag=0x03, mem_ready=1 → header 0x000003A5 @0, then 0xDEADBEEF @1. mem_wr high 2 cycles starting 1 cycle after the match edge. rec_count=1, busy=0 afterwards.
- Backpressure: mem_ready low for 5 cycles during WR_HDR → mem_wr/addr/wdata stable throughout. The record completes 2 cycles after mem_ready rises.
- Overflow: ADDR_W default, FIFO_DEPTH=4, mem_ready=0, 6 consecutive matches → 4 buffered, drop_count=2. Releasing mem_ready writes 4 records with seq 0..3 in order.
- Full (no LOGGER_WRAP_EN, ADDR_W=4): 9 matches spaced 3 cycles apart → 8 records at addr 0–15, log_full=1 after the 8th, drop_count=1, mem_wr not reasserted.
- Wrap (LOGGER_WRAP_EN, ADDR_W=4): 9 matches → 9th header written at addr 0 with seq=8, log_full=0, rec_count=8.
- Reset mid-record: rst asserted in WR_DATA → next cycle all outputs at reset values. A subsequent match is logged at addr 0 with seq 0.
